serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial N-bit adder controller. Accepts two WIDTH-bit operands and a carry-in over a
//   valid/ready handshake, then sequences one full-adder cell (two halfAdder cells plus an OR)
//   LSB-first, one bit per clock. Returns sum/cout over a valid/ready handshake.
//   Gives area-minimal addition for the arithmetic blocks; trades latency for a single adder cell.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range 1..32
// PORTS
//   clk        in   1      sole clock; all state updates on rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands a, b and cin present
//   in_ready   out  1      controller can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A, sampled on accept
//   b          in   WIDTH  operand B, sampled on accept
//   cin        in   1      carry-in, sampled on accept
//   out_valid  out  1      sum/cout valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  a+b+cin, low WIDTH bits
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; sum=0, cout=0, out_valid=0, busy=0; bit counter=0;
//     operand shift regs=0; in_ready=1 once rst deasserts. Reset mid-RUN/DONE aborts with no output.
//   FSM, states IDLE, RUN, DONE:
//     IDLE: in_ready=1. On in_valid&in_ready, latch a->sa, b->sb, cin->carry, cnt=0; go RUN.
//     RUN: each cycle, FA(sa[0], sb[0], carry) -> s, c. Shift sa, sb right by 1; shift s into
//       sum MSB (sum shifts right); carry<=c; cnt++. When cnt==WIDTH-1 this cycle -> DONE.
//     DONE: out_valid=1; cout=carry. Hold sum/cout stable until out_valid&out_ready; then -> IDLE.
//   Latency: out_valid rises exactly WIDTH cycles after the accept edge.
//     Minimum period between accepts: WIDTH+2 cycles.
//   in_valid in RUN/DONE: ignored (in_ready=0). Changes to a/b/cin after accept have no effect.
//   out_ready high in DONE on arrival: one-cycle out_valid pulse; IDLE next cycle.
//   out_ready low: stay in DONE indefinitely; no timeout.
//   WIDTH=1: RUN lasts one cycle; counter width = max($clog2(WIDTH),1); counter never wraps.
//   sum is don't-care (partially shifted) during RUN; only valid while out_valid=1.
//   No combinational path from in_valid to in_ready, or from out_ready to out_valid.
// STRUCTURE
//   serial_add_pkg: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) as localparams,
//     plus the max WIDTH constant.
//   Sub-module serial_fa_bit: a full adder built from two halfAdder instances; carry = OR of
//     the two half-adder carries. The controller instantiates it exactly once.
//   Top: FSM, bit counter, two operand shift regs, sum shift reg, carry flop.
// TESTING
//   1 WIDTH=8, a=0x3C b=0x5A cin=0 -> out_valid 8 cycles after accept; sum=0x96, cout=0
//   2 a=0xFF b=0x01 cin=0 -> sum=0x00, cout=1; a=0xFF b=0xFF cin=1 -> sum=0xFF, cout=1
//   3 out_ready held low 5 cycles in DONE -> sum/cout stable, in_ready=0; new in_valid ignored;
//     accept on out_ready=1, then IDLE
//   4 rst pulsed at 3rd RUN cycle -> out_valid=0, sum=0, busy=0 immediately (async);
//     in_ready=1 after release; the next op computes correctly
//   5 back-to-back in_valid held high, out_ready=1 -> accepts exactly every WIDTH+2 cycles
//   6 WIDTH=1: a=1 b=1 cin=0 -> sum=0, cout=1, out_valid 1 cycle after accept;
//     random 1000-op check vs a+b+cin at WIDTH=8

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and width limit for the bit-serial adder.
package serial_add_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/half_adder.sv
// half_adder: one-bit half adder; ports a, b in; s (xor) and c (and) out.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_fa_bit.sv
// serial_fa_bit: full adder cell from two half adders; ports a, b, ci in; s, co out.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0, c0, c1;
    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));
    assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder; in_valid/in_ready take a, b, cin; out_valid/out_ready return sum, cout; busy flags RUN/DONE.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sum_r;
    logic             carry, fa_s, fa_c, last;
    logic [CW-1:0]    cnt;
    serial_fa_bit u_fa (.a(sa[0]), .b(sb[0]), .ci(carry), .s(fa_s), .co(fa_c));
    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign busy      = state != ST_IDLE;
    assign sum       = sum_r;
    assign cout      = out_valid & carry;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    always_comb begin
        state_nxt = state;
        state_nxt = (state == ST_IDLE) ? (in_valid ? ST_RUN : ST_IDLE) :
                    (state == ST_RUN)  ? (last ? ST_DONE : ST_RUN) :
                                         (out_ready ? ST_IDLE : ST_DONE);
    end
    // Sum enters at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == ST_IDLE && in_valid) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sum_r <= WIDTH'({fa_s, sum_r} >> 1);
            carry <= fa_c;
            cnt   <= last ? cnt : cnt + 1'b1;
        end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout, busy;
    logic [7:0] a = '0, b = '0, sum;
    logic       w1_in_valid = 1'b0, w1_in_ready, w1_cin = 1'b0, w1_out_valid, w1_out_ready = 1'b0, w1_cout, w1_busy;
    logic [0:0] w1_a = '0, w1_b = '0, w1_sum;
    int         n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );
    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .a(w1_a), .b(w1_b),
        .cin(w1_cin), .out_valid(w1_out_valid), .out_ready(w1_out_ready), .sum(w1_sum),
        .cout(w1_cout), .busy(w1_busy)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    // One complete transaction on the WIDTH=8 instance, driven and sampled on negedges.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c, input int hold,
                       input bit early, input bit poke);
        logic [8:0] ref_v;
        int lat;
        ref_v = 9'(x) + 9'(y) + 9'(c);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; a = x; b = y; cin = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; a = ~x; b = ~y; cin = ~c;
        out_ready = early;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 8);
        check("sum", sum, ref_v[7:0]);
        check("cout", cout, ref_v[8]);
        for (int i = 0; i < hold && !early; i++) begin
            if (poke) begin
                in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
            end
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_sum", {cout, sum}, ref_v);
            check("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("back_idle", {out_valid, in_ready}, 2'b01);
        if (poke) begin
            @(negedge clk);
            check("poke_ignored", busy, 1'b0);
        end
    endtask
    initial begin
        int acc[$];
        int cyc, waitc;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", {cout, sum}, 9'h0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        op8(8'h3C, 8'h5A, 1'b0, 0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 0, 1'b1, 1'b0);
        op8(8'hA5, 8'h3B, 1'b1, 5, 1'b0, 1'b1);
        in_valid = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_sum", sum, 8'h00);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_in_ready", in_ready, 1'b1);
        op8(8'h77, 8'h19, 1'b1, 1, 1'b0, 1'b0);
        in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0; out_ready = 1'b1;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) check("b2b_sum", {cout, sum}, 9'h003);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_count", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++) check("b2b_period", acc[i] - acc[i-1], 10);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        out_ready = 1'b0;
        check("b2b_drain", in_ready, 1'b1);
        w1_in_valid = 1'b1; w1_a = 1'b1; w1_b = 1'b1; w1_cin = 1'b0;
        @(negedge clk);
        w1_in_valid = 1'b0;
        check("w1_run", w1_out_valid, 1'b0);
        @(negedge clk);
        check("w1_valid", w1_out_valid, 1'b1);
        check("w1_result", {w1_cout, w1_sum}, 2'b10);
        w1_out_ready = 1'b1;
        @(negedge clk);
        w1_out_ready = 1'b0;
        check("w1_idle", w1_in_ready, 1'b1);
        for (int n = 0; n < 1000; n++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 3) == 0), 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
